pu_msp430_reset_ctrl: RTL

Reset sequencer sitting directly downstream of the reset synchronizer: consumes the synchronized system reset and produces the stretched power-on reset (`por`) and power-up-clear (`puc_rst`) distributed to the CPU core and peripherals. It also merges the run-time reset sources (watchdog, software, debug unit) into PUC sequences and keeps a sticky reset-cause record for the SFR block. All outputs are registered and free of glitches.

---
 rtl/pu_msp430_reset_pkg.sv | 25 ++
 rtl/pu_msp430_reset_stretch.sv | 25 ++
 rtl/pu_msp430_reset_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pu_msp430_reset_pkg.sv
// Shared types and constants for the MSP430 reset sequencer.
package pu_msp430_reset_pkg;

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    PUC_HOLD = 2'd1,
    RUN      = 2'd2
  } rst_state_e;

  localparam int CAUSE_W   = 4;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_SW  = 2;
  localparam int CAUSE_DBG = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_POR_ONLY = 4'b0001;

  // Counter width able to hold the larger of the two stretch lengths.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pu_msp430_reset_stretch.sv
// Loadable down-counter shared by the POR and PUC hold phases.
module pu_msp430_reset_stretch #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Asserted when the decrement on this edge brings the count to zero.
  assign last = (cnt <= W'(1));

endmodule

// File: rtl/pu_msp430_reset_ctrl.sv
// Reset sequencer: stretches POR/PUC, merges run-time reset requests, records causes.
module pu_msp430_reset_ctrl
  import pu_msp430_reset_pkg::*;
#(
  parameter int POR_CYCLES = 16,
  parameter int PUC_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_s,
  input  logic               wdt_reset,
  input  logic               sw_reset,
  input  logic               dbg_cpu_reset,
  input  logic               cause_clr,
  output logic               por,
  output logic               puc_rst,
  output logic               rst_done,
  output logic [CAUSE_W-1:0] rst_cause
);

  localparam int CNT_W = cnt_width(POR_CYCLES, PUC_CYCLES);

  rst_state_e         state, state_nxt;
  logic               por_nxt, puc_nxt, done_nxt;
  logic               cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0]   cnt_val;
  logic [CAUSE_W-1:0] cause_set, cause_nxt;
  logic               any_req;

  assign any_req = wdt_reset | sw_reset | dbg_cpu_reset;

  pu_msp430_reset_stretch #(.W(CNT_W)) u_stretch (
    .clk      (clk),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    por_nxt   = por;
    puc_nxt   = puc_rst;
    done_nxt  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = CNT_W'(PUC_CYCLES);
    if (rst_s) begin
      state_nxt = POR_HOLD;
      por_nxt   = 1'b1;
      puc_nxt   = 1'b1;
      cnt_load  = 1'b1;
      cnt_val   = CNT_W'(POR_CYCLES);
    end else begin
      case (state)
        POR_HOLD: begin
          if (cnt_last) begin
            state_nxt = PUC_HOLD;
            por_nxt   = 1'b0;
            cnt_load  = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        PUC_HOLD: begin
          // Any request, including a held debug reset, restarts the stretch.
          if (any_req) begin
            cnt_load = 1'b1;
          end else if (cnt_last) begin
            state_nxt = RUN;
            puc_nxt   = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        RUN: begin
          if (any_req) begin
            state_nxt = PUC_HOLD;
            puc_nxt   = 1'b1;
            cnt_load  = 1'b1;
          end
        end
        default: begin
          state_nxt = POR_HOLD;
          por_nxt   = 1'b1;
          puc_nxt   = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(POR_CYCLES);
        end
      endcase
    end
  end

  // Requests during POR_HOLD are not recorded; a coincident set survives a clear.
  always_comb begin
    cause_set = '0;
    if (state != POR_HOLD) begin
      cause_set[CAUSE_WDT] = wdt_reset;
      cause_set[CAUSE_SW]  = sw_reset;
      cause_set[CAUSE_DBG] = dbg_cpu_reset;
    end
    cause_nxt = cause_clr ? cause_set : (rst_cause | cause_set);
  end

  always_ff @(posedge clk) begin
    if (rst_s) begin
      state     <= POR_HOLD;
      por       <= 1'b1;
      puc_rst   <= 1'b1;
      rst_done  <= 1'b0;
      rst_cause <= CAUSE_POR_ONLY;
    end else begin
      state     <= state_nxt;
      por       <= por_nxt;
      puc_rst   <= puc_nxt;
      rst_done  <= done_nxt;
      rst_cause <= cause_nxt;
    end
  end

endmodule
